// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Merges two register-file writeback streams into the single write port of a
// register file. Port A carries ALU results and port B carries load results.
// Each port has its own 2-entry FIFO. A round-robin arbiter drains one FIFO
// head per cycle onto a registered write port.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// x_valid && x_ready are both high. x_ready depends only on registered
// occupancy, flush and reset, so it never depends on a pop in the same cycle.
// A transfer with x_rd == 0 is accepted but not queued, because writes to x0
// are architecturally discarded.
//
// Parameters
//   DATA_W         writeback data width
//   ADDR_W         register index width
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-high reset
//   flush          synchronous discard of every queued and in-flight write
//   a_valid        port A request
//   a_ready        port A can accept this cycle
//   a_rd           port A destination register
//   a_data         port A write data
//   b_valid        port B request
//   b_ready        port B can accept this cycle
//   b_rd           port B destination register
//   b_data         port B write data
//   Regwrite       register-file write enable (registered)
//   writeRegister  register-file write index (registered)
//   writeData      register-file write data (registered)
//   busy           a write is queued or is being driven
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,

    output logic              Regwrite,
    output logic [ADDR_W-1:0] writeRegister,
    output logic [DATA_W-1:0] writeData,
    output logic              busy
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    // -----------------------------------------------------------------------
    // Port A FIFO state
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifoA [2];
    logic [1:0]         countA;
    logic               wrPtrA;
    logic               rdPtrA;
    logic [ENTRY_W-1:0] headA;
    logic               pushA;
    logic               nonEmptyA;

    // -----------------------------------------------------------------------
    // Port B FIFO state
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifoB [2];
    logic [1:0]         countB;
    logic               wrPtrB;
    logic               rdPtrB;
    logic [ENTRY_W-1:0] headB;
    logic               pushB;
    logic               nonEmptyB;

    // -----------------------------------------------------------------------
    // Arbiter state
    // -----------------------------------------------------------------------
    // preferB = 0 means port A wins a tie. After a grant the preference moves
    // to the port that was not granted.
    logic               preferB;
    logic               grantA;
    logic               grantB;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // Ready comes from the registered count only. A full FIFO that is popped
    // this cycle still reports not-ready; it reports ready again next cycle.
    assign a_ready = !reset && (countA != 2'd2) && !flush;
    assign b_ready = !reset && (countB != 2'd2) && !flush;

    // Writes to x0 complete the handshake but never occupy a FIFO slot.
    assign pushA = a_valid && a_ready && (a_rd != '0);
    assign pushB = b_valid && b_ready && (b_rd != '0);

    assign nonEmptyA = (countA != 2'd0);
    assign nonEmptyB = (countB != 2'd0);

    assign headA = fifoA[rdPtrA];
    assign headB = fifoB[rdPtrB];

    // -----------------------------------------------------------------------
    // Round-robin grant
    // -----------------------------------------------------------------------
    // At most one grant per cycle. A lone non-empty FIFO wins regardless of
    // the pointer. Flush suppresses the grant so nothing leaks past a flush.
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (!flush) begin
            if (nonEmptyA && nonEmptyB) begin
                grantA = !preferB;
                grantB = preferB;
            end else if (nonEmptyA) begin
                grantA = 1'b1;
            end else if (nonEmptyB) begin
                grantB = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Port A FIFO control
    // -----------------------------------------------------------------------
    // A simultaneous push and pop leaves the count unchanged. Both pointers
    // still advance, so FIFO order is preserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countA <= 2'd0;
            wrPtrA <= 1'b0;
            rdPtrA <= 1'b0;
        end else if (flush) begin
            countA <= 2'd0;
            wrPtrA <= 1'b0;
            rdPtrA <= 1'b0;
        end else begin
            if (pushA) begin
                wrPtrA <= ~wrPtrA;
            end
            if (grantA) begin
                rdPtrA <= ~rdPtrA;
            end
            case ({pushA, grantA})
                2'b10:   countA <= countA + 2'd1;
                2'b01:   countA <= countA - 2'd1;
                default: countA <= countA;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (pushA) begin
            fifoA[wrPtrA] <= {a_rd, a_data};
        end
    end

    // -----------------------------------------------------------------------
    // Port B FIFO control
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countB <= 2'd0;
            wrPtrB <= 1'b0;
            rdPtrB <= 1'b0;
        end else if (flush) begin
            countB <= 2'd0;
            wrPtrB <= 1'b0;
            rdPtrB <= 1'b0;
        end else begin
            if (pushB) begin
                wrPtrB <= ~wrPtrB;
            end
            if (grantB) begin
                rdPtrB <= ~rdPtrB;
            end
            case ({pushB, grantB})
                2'b10:   countB <= countB + 2'd1;
                2'b01:   countB <= countB - 2'd1;
                default: countB <= countB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushB) begin
            fifoB[wrPtrB] <= {b_rd, b_data};
        end
    end

    // -----------------------------------------------------------------------
    // Priority pointer
    // -----------------------------------------------------------------------
    // The pointer holds across flush, because flush forces both grants low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preferB <= 1'b0;
        end else if (grantA) begin
            preferB <= 1'b1;
        end else if (grantB) begin
            preferB <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Registered write port
    // -----------------------------------------------------------------------
    // The index and data hold between writes, so only Regwrite pulses.
    // Queued entries never have rd == 0, so Regwrite is never paired with x0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Regwrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else if (flush) begin
            Regwrite      <= 1'b0;
        end else if (grantA) begin
            Regwrite      <= 1'b1;
            writeRegister <= headA[ENTRY_W-1:DATA_W];
            writeData     <= headA[DATA_W-1:0];
        end else if (grantB) begin
            Regwrite      <= 1'b1;
            writeRegister <= headB[ENTRY_W-1:DATA_W];
            writeData     <= headB[DATA_W-1:0];
        end else begin
            Regwrite      <= 1'b0;
        end
    end

    assign busy = nonEmptyA || nonEmptyB || Regwrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter.
// - Driver: driveCycle applies one cycle of stimulus. It records each accepted
//   non-x0 write in that port's expected queue.
// - Scoreboard: on every falling edge with Regwrite high, the monitor matches
//   the write against the head of port A's or port B's expected queue. It also
//   logs which port the write came from.
// - Scenario tasks: each task checks its own timing-specific outputs inline.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int KEY_W  = ADDR_W + DATA_W;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              b_valid = 1'b0;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              Regwrite;
    logic [ADDR_W-1:0] writeRegister;
    logic [DATA_W-1:0] writeData;
    logic              busy;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_rd          (a_rd),
        .a_data        (a_data),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_rd          (b_rd),
        .b_data        (b_data),
        .Regwrite      (Regwrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .busy          (busy)
    );

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int checks = 0;
    int fails = 0;
    int cycleCount = 0;

    logic [KEY_W-1:0] expA [$];
    logic [KEY_W-1:0] expB [$];
    logic             srcLog [$];   // 0 = came from A, 1 = came from B
    int               srcCyc [$];

    logic lastAReady;
    logic lastBReady;
    logic dummyA;
    logic dummyB;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // -----------------------------------------------------------------------
    // Scoreboard monitor
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        logic [KEY_W-1:0] key;
        if (!reset && Regwrite === 1'b1) begin
            key = {writeRegister, writeData};
            checks++;
            if (writeRegister == '0) begin
                fails++;
                $display("FAIL x0_write: Regwrite with writeRegister=%0d data=%h (required nonzero index)",
                         writeRegister, writeData);
            end else if (expA.size() > 0 && expA[0] == key) begin
                void'(expA.pop_front());
                srcLog.push_back(1'b0);
                srcCyc.push_back(cycleCount);
            end else if (expB.size() > 0 && expB[0] == key) begin
                void'(expB.pop_front());
                srcLog.push_back(1'b1);
                srcCyc.push_back(cycleCount);
            end else begin
                fails++;
                $display("FAIL scoreboard: got rd=%0d data=%h, required head of A (%0d queued) or B (%0d queued)",
                         writeRegister, writeData, expA.size(), expB.size());
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    // Called just after a rising edge. Drives one cycle, samples readiness at
    // the falling edge, and returns 1 time unit after the next rising edge.
    task automatic driveCycle(input logic av, input logic [ADDR_W-1:0] ard,
                              input logic [DATA_W-1:0] ad,
                              input logic bv, input logic [ADDR_W-1:0] brd,
                              input logic [DATA_W-1:0] bd,
                              output logic accA, output logic accB);
        a_valid = av;
        a_rd    = ard;
        a_data  = ad;
        b_valid = bv;
        b_rd    = brd;
        b_data  = bd;
        @(negedge clk);
        lastAReady = a_ready;
        lastBReady = b_ready;
        accA = av && a_ready;
        accB = bv && b_ready;
        @(posedge clk);
        if (accA && ard != '0) expA.push_back({ard, ad});
        if (accB && brd != '0) expB.push_back({brd, bd});
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic idleCycle();
        driveCycle(1'b0, '0, '0, 1'b0, '0, '0, dummyA, dummyB);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        flush   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expA.delete();
        expB.delete();
        srcLog.delete();
        srcCyc.delete();
    endtask

    // Idle until both expected queues drain and busy falls, up to maxCycles.
    task automatic drain(input int maxCycles, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            if (expA.size() == 0 && expB.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            idleCycle();
        end
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({Regwrite, busy, a_ready, b_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: {Regwrite,busy,a_ready,b_ready}=%b required 0000",
                     {Regwrite, busy, a_ready, b_ready});
        end
        checks++;
        if (writeRegister !== '0 || writeData !== '0) begin
            fails++;
            $display("FAIL reset_data: writeRegister=%0d writeData=%h required 0 and 0",
                     writeRegister, writeData);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b11) begin
            fails++;
            $display("FAIL reset_release_ready: {a_ready,b_ready}=%b required 11", {a_ready, b_ready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic accA;
        logic accB;
        driveCycle(1'b1, 5'd5, 64'h1234, 1'b0, '0, '0, accA, accB);
        checks++;
        if ({accA, Regwrite, busy} !== 3'b101) begin
            fails++;
            $display("FAIL single_after_edge0: {accepted,Regwrite,busy}=%b required 101", {accA, Regwrite, busy});
        end
        idleCycle();
        checks++;
        if (Regwrite !== 1'b1 || writeRegister !== 5'd5 || writeData !== 64'h1234) begin
            fails++;
            $display("FAIL single_write: Regwrite=%b rd=%0d data=%h required 1, 5, 1234",
                     Regwrite, writeRegister, writeData);
        end
        idleCycle();
        checks++;
        if ({Regwrite, busy} !== 2'b00) begin
            fails++;
            $display("FAIL single_after: {Regwrite,busy}=%b required 00", {Regwrite, busy});
        end
    endtask

    task automatic test_x0_drop();
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            driveCycle(1'b0, '0, '0, 1'b1, 5'd0, 64'hFFFF, dummyA, dummyB);
            if ({lastAReady, lastBReady, Regwrite, busy} !== 4'b1100) bad = 1'b1;
        end
        idleCycle();
        if ({Regwrite, busy} !== 2'b00) bad = 1'b1;
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL x0_drop: last {a_ready,b_ready,Regwrite,busy}=%b required 1100 throughout",
                     {lastAReady, lastBReady, Regwrite, busy});
        end
    endtask

    task automatic test_contention();
        int ia;
        int ib;
        logic accA;
        logic accB;
        logic sawALow;
        logic sawBLow;
        logic ok;
        logic [5:0] pat;
        doReset();
        ia = 0;
        ib = 0;
        sawALow = 1'b0;
        sawBLow = 1'b0;
        for (int c = 0; c < 8; c++) begin
            driveCycle(ia < 3, ADDR_W'(10 + ia), DATA_W'(64'hA0 + ia),
                       ib < 3, ADDR_W'(20 + ib), DATA_W'(64'hB0 + ib), accA, accB);
            if (accA) ia++;
            if (accB) ib++;
            if (!lastAReady) sawALow = 1'b1;
            if (!lastBReady) sawBLow = 1'b1;
        end
        drain(20, ok);
        checks++;
        if (!ok || ia != 3 || ib != 3) begin
            fails++;
            $display("FAIL contention_drain: drained=%b acceptedA=%0d acceptedB=%0d required 1, 3, 3", ok, ia, ib);
        end
        checks++;
        if (srcLog.size() != 6) begin
            fails++;
            $display("FAIL contention_count: writes=%0d required 6", srcLog.size());
        end else begin
            pat = '0;
            for (int i = 0; i < 6; i++) pat[i] = srcLog[i];
            checks++;
            if (pat !== 6'b101010) begin
                fails++;
                $display("FAIL contention_order: sources (bit0 first, 1=B) %b required 101010", pat);
            end
            checks++;
            if (srcCyc[5] - srcCyc[0] != 5) begin
                fails++;
                $display("FAIL contention_rate: span=%0d cycles required 5", srcCyc[5] - srcCyc[0]);
            end
        end
        checks++;
        if ({sawALow, sawBLow} !== 2'b11) begin
            fails++;
            $display("FAIL contention_backpressure: saw low {a_ready,b_ready}=%b required 11", {sawALow, sawBLow});
        end
    endtask

    task automatic test_full_pop();
        int ia;
        int ib;
        int lows;
        int lowAt;
        logic accA;
        logic accB;
        logic ok;
        logic readyHist [10];
        logic [4:0] pat;
        doReset();
        ia = 0;
        ib = 0;
        for (int c = 0; c < 10; c++) begin
            driveCycle(ia < 4, ADDR_W'(1 + ia), DATA_W'(64'hF00 + ia),
                       ib < 1, 5'd7, 64'h777, accA, accB);
            if (accA) ia++;
            if (accB) ib++;
            readyHist[c] = lastAReady;
        end
        lows = 0;
        lowAt = -1;
        for (int c = 0; c < 10; c++) begin
            if (!readyHist[c]) begin
                lows++;
                if (lowAt < 0) lowAt = c;
            end
        end
        checks++;
        if (lows != 1 || lowAt != 3) begin
            fails++;
            $display("FAIL full_pop_ready: a_ready low %0d cycle(s), first at %0d, required 1 at 3", lows, lowAt);
        end
        drain(20, ok);
        checks++;
        if (!ok || ia != 4 || srcLog.size() != 5) begin
            fails++;
            $display("FAIL full_pop_count: drained=%b acceptedA=%0d writes=%0d required 1, 4, 5",
                     ok, ia, srcLog.size());
        end else begin
            for (int i = 0; i < 5; i++) pat[i] = srcLog[i];
            checks++;
            if (pat !== 5'b00010) begin
                fails++;
                $display("FAIL full_pop_order: sources (bit0 first, 1=B) %b required 00010", pat);
            end
        end
    endtask

    task automatic test_flush();
        logic sawWrite;
        doReset();
        driveCycle(1'b1, 5'd11, 64'h11, 1'b1, 5'd21, 64'h21, dummyA, dummyB);
        driveCycle(1'b1, 5'd12, 64'h12, 1'b0, '0, '0, dummyA, dummyB);
        driveCycle(1'b1, 5'd13, 64'h13, 1'b1, 5'd22, 64'h22, dummyA, dummyB);
        flush = 1'b1;
        idleCycle();
        flush = 1'b0;
        checks++;
        if ({Regwrite, busy, lastAReady, lastBReady} !== 4'b0000) begin
            fails++;
            $display("FAIL flush_clear: {Regwrite,busy,a_ready_in_flush,b_ready_in_flush}=%b required 0000",
                     {Regwrite, busy, lastAReady, lastBReady});
        end
        checks++;
        if (expA.size() != 2 || expB.size() != 1) begin
            fails++;
            $display("FAIL flush_pending: pending A=%0d B=%0d required 2 and 1", expA.size(), expB.size());
        end
        expA.delete();
        expB.delete();
        sawWrite = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idleCycle();
            if (Regwrite !== 1'b0 || busy !== 1'b0) sawWrite = 1'b1;
        end
        checks++;
        if (sawWrite || {a_ready, b_ready} !== 2'b11) begin
            fails++;
            $display("FAIL flush_after: stale activity=%b {a_ready,b_ready}=%b required 0, 11",
                     sawWrite, {a_ready, b_ready});
        end
    endtask

    task automatic test_async_reset();
        logic stale;
        doReset();
        for (int i = 0; i < 3; i++) begin
            driveCycle(1'b1, ADDR_W'(1 + i), DATA_W'(64'hC0 + i),
                       1'b1, ADDR_W'(9 + i), DATA_W'(64'hD0 + i), dummyA, dummyB);
        end
        checks++;
        if ({Regwrite, busy} !== 2'b11) begin
            fails++;
            $display("FAIL async_pre: {Regwrite,busy}=%b required 11", {Regwrite, busy});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({Regwrite, busy, a_ready, b_ready} !== 4'b0000 || writeRegister !== '0 || writeData !== '0) begin
            fails++;
            $display("FAIL async_reset: {Regwrite,busy,a_ready,b_ready}=%b rd=%0d data=%h required 0000, 0, 0",
                     {Regwrite, busy, a_ready, b_ready}, writeRegister, writeData);
        end
        expA.delete();
        expB.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idleCycle();
            if (Regwrite !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            fails++;
            $display("FAIL async_stale: write or busy seen after reset release, required none");
        end
    endtask

    task automatic test_random();
        logic ok;
        for (int c = 0; c < 300; c++) begin
            driveCycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), {$urandom(), $urandom()},
                       1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), {$urandom(), $urandom()},
                       dummyA, dummyB);
        end
        drain(40, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL random_drain: pending A=%0d B=%0d busy=%b required 0, 0, 0",
                     expA.size(), expB.size(), busy);
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_x0_drop();
        test_contention();
        test_full_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W  64  writeback data width
  ADDR_W  5  register index width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge
  reset  in  1  asynchronous, active-high reset
  flush  in  1  synchronous discard of all queued and in-flight writes
  a_valid  in  1  port A (ALU writeback) request
  a_ready  out  1  port A can accept this cycle
  a_rd  in  ADDR_W  port A destination register
  a_data  in  DATA_W  port A write data
  b_valid  in  1  port B (load writeback) request
  b_ready  out  1  port B can accept this cycle
  b_rd  in  ADDR_W  port B destination register
  b_data  in  DATA_W  port B write data
  Regwrite  out  1  register-file write enable
  writeRegister  out  ADDR_W  register-file write index
  writeData  out  DATA_W  register-file write data
  busy  out  1  any write queued or being driven
REQ-003 clk SHALL be the only clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 Each port SHALL own a 2-entry FIFO of {rd, data} with a registered occupancy count (0..2) and wrapping 1-bit read and write pointers.
REQ-005 x_ready SHALL be (count_x != 2) && !flush, computed from registered state only; it SHALL NOT depend on a same-cycle pop.
REQ-006 A transfer SHALL occur on a rising edge where x_valid && x_ready; rd != 0 SHALL be enqueued; rd == 0 SHALL be accepted and discarded with no count change.
REQ-007 Each cycle the arbiter SHALL grant exactly one non-empty FIFO, or none when both are empty; a grant SHALL pop that FIFO's head at the next edge.
REQ-008 Arbitration SHALL be round-robin with a 1-bit priority pointer: when both FIFOs are non-empty the preferred port wins; when one is non-empty it wins regardless of pointer.
REQ-009 After any grant the pointer SHALL point to the non-granted port; with no grant it SHALL hold.
REQ-010 Regwrite, writeRegister and writeData SHALL be registered: a head granted in cycle N SHALL appear on them for exactly cycle N+1; with no grant in cycle N, Regwrite SHALL be 0 in N+1 and writeRegister/writeData SHALL hold.
REQ-011 Minimum latency SHALL be 2 edges: accepted at edge E, granted in the cycle after E, Regwrite high in the cycle after edge E+1.
REQ-012 Regwrite SHALL never be 1 with writeRegister == 0.
REQ-013 Simultaneous push and pop on the same FIFO SHALL leave count unchanged and preserve FIFO order.
REQ-014 Order within a port SHALL be strictly preserved; order between ports is arbitration order only.
REQ-015 flush high at an edge SHALL zero both counts and pointers, clear Regwrite, and suppress that cycle's push and grant; the priority pointer SHALL hold.
REQ-016 busy SHALL be (count_a != 0) || (count_b != 0) || Regwrite.
REQ-017 Sustained throughput SHALL be one register write per cycle while either FIFO is non-empty.

Reset
REQ-018 While reset is high, and immediately on its assertion: counts = 0, pointers = 0, priority = port A, Regwrite = 0, writeRegister = 0, writeData = 0, busy = 0, a_ready = b_ready = 0 only while reset asserted.
REQ-019 Reset asserted mid-operation SHALL discard all queued writes; no Regwrite pulse SHALL occur after reset deassertion until a new transfer.

Verification
REQ-020 Single write: A pushes rd=5, data=0x1234 at edge 0 -> Regwrite=1, writeRegister=5, writeData=0x1234 for exactly the cycle after edge 1; busy=0 afterwards.
REQ-021 Contention: A and B each push 3 writes back-to-back from reset -> outputs alternate A,B,A,B,A,B, one per cycle; per-port order preserved; a_ready/b_ready drop to 0 while count=2.
REQ-022 x0 drop: B pushes rd=0, data=0xFFFF -> a_ready/b_ready stay high, Regwrite never asserts, busy stays 0.
REQ-023 Full-plus-pop: fill A to 2, hold a_valid=1 -> a_ready=0 during the pop cycle, returns to 1 the next cycle; no entry lost or duplicated.
REQ-024 Flush: A holds 2 entries, B 1, flush pulsed one cycle -> next cycle Regwrite=0, busy=0, no queued write ever appears.
REQ-025 Async reset mid-stream: reset asserted between edges with both FIFOs full -> Regwrite and busy drop to 0 immediately; after release no stale write is emitted.
